// File: rtl/kypd_pkg.sv
// Shared types and constants for the Pmod KYPD 4x4 keypad scan controller.
package kypd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_EVAL
    } scan_state_t;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } frame_class_t;

    // Indexed [row][col]; row 0 is the top row of the keypad, col 0 the left column.
    localparam logic [CODE_W-1:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

endpackage

// File: rtl/kypd_key_fifo.sv
// Small synchronous key-code FIFO with a registered head, registered
// not-empty flag and a sticky overflow flag.
module kypd_key_fifo
    import kypd_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [CODE_W-1:0] push_code_i,
    input  logic              pop_i,
    input  logic              clr_overflow_i,
    output logic [CODE_W-1:0] head_o,
    output logic              avail_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o
);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CODE_W-1:0] head_q, head_d;
    logic              avail_q, avail_d;
    logic              overflow_q, overflow_d;
    logic              isEmpty, isFull, popOk, pushOk;

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == CW'(DEPTH));

    always_comb begin
        popOk      = pop_i && !isEmpty;
        pushOk     = push_i && (!isFull || popOk);
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        head_d     = '0;

        if (pushOk) wrPtr_d = wrPtr_q + AW'(1);
        if (popOk)  rdPtr_d = rdPtr_q + AW'(1);
        if (pushOk && !popOk)      count_d = count_q + CW'(1);
        else if (!pushOk && popOk) count_d = count_q - CW'(1);

        // A fresh overflow takes priority over a clear in the same cycle.
        if (push_i && isFull && !popOk) overflow_d = 1'b1;
        else if (clr_overflow_i)        overflow_d = 1'b0;

        avail_d = (count_d != '0);
        // When the new head is the slot being written this edge, forward the pushed code.
        if (avail_d) begin
            if (pushOk && (wrPtr_q == rdPtr_d)) head_d = push_code_i;
            else                                head_d = mem_q[rdPtr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (pushOk) mem_q[wrPtr_q] <= push_code_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            head_q     <= '0;
            avail_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            avail_q    <= avail_d;
            overflow_q <= overflow_d;
        end
    end

    assign head_o     = head_q;
    assign avail_o    = avail_q;
    assign count_o    = count_q;
    assign full_o     = isFull;
    assign empty_o    = isEmpty;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/kypd_scan_ctrl.sv
// Column-scanning controller for the Pmod KYPD: walks the columns, builds a
// 16-bit frame, debounces the classified result and queues new key codes.
module kypd_scan_ctrl
    import kypd_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_COLS-1:0] col_o,
    input  logic                fifo_pop,
    input  logic                clr_overflow,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_avail,
    output logic [CW-1:0]       fifo_count,
    output logic                overflow,
    output logic                key_down,
    output logic                multi_key,
    output logic                irq
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int FW = NUM_ROWS * NUM_COLS;

    logic [NUM_ROWS-1:0] rowMeta_q, rowSync_q;
    scan_state_t         state_q, state_d;
    logic [1:0]          colIdx_q, colIdx_d;
    logic [SW-1:0]       settleCnt_q, settleCnt_d;
    logic [FW-1:0]       frame_q, frame_d;
    frame_class_t        prevClass_q, prevClass_d, commClass_q, commClass_d, candClass;
    logic [CODE_W-1:0]   prevCode_q, prevCode_d, commCode_q, commCode_d, candCode;
    logic [DW-1:0]       dbCnt_q, dbCnt_d, cntNext;
    logic                irq_q;
    logic [4:0]          nSet;
    logic [3:0]          hitIdx;
    logic                commitNow, keyPush, fifoFull, fifoEmpty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rowMeta_q   <= '1;
            rowSync_q   <= '1;
            state_q     <= S_IDLE;
            colIdx_q    <= '0;
            settleCnt_q <= '0;
            frame_q     <= '0;
            prevClass_q <= NONE;
            prevCode_q  <= '0;
            dbCnt_q     <= '0;
            commClass_q <= NONE;
            commCode_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            rowMeta_q   <= row_i;
            rowSync_q   <= rowMeta_q;
            state_q     <= state_d;
            colIdx_q    <= colIdx_d;
            settleCnt_q <= settleCnt_d;
            frame_q     <= frame_d;
            prevClass_q <= prevClass_d;
            prevCode_q  <= prevCode_d;
            dbCnt_q     <= dbCnt_d;
            commClass_q <= commClass_d;
            commCode_q  <= commCode_d;
            irq_q       <= keyPush && (!fifoFull || (fifo_pop && !fifoEmpty));
        end
    end

    always_comb begin
        state_d     = state_q;
        colIdx_d    = colIdx_q;
        settleCnt_d = settleCnt_q;
        frame_d     = frame_q;
        if (!enable) begin
            state_d     = S_IDLE;
            colIdx_d    = '0;
            settleCnt_d = '0;
            frame_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d     = S_DRIVE;
                    colIdx_d    = '0;
                    settleCnt_d = '0;
                    frame_d     = '0;
                end
                S_DRIVE: begin
                    if (settleCnt_q == SW'(SETTLE_CYCLES - 1)) state_d = S_SAMPLE;
                    else settleCnt_d = settleCnt_q + SW'(1);
                end
                S_SAMPLE: begin
                    frame_d[{colIdx_q, 2'b00} +: NUM_ROWS] = ~rowSync_q;
                    settleCnt_d = '0;
                    if (colIdx_q == 2'd3) begin
                        state_d = S_EVAL;
                    end else begin
                        state_d  = S_DRIVE;
                        colIdx_d = colIdx_q + 2'd1;
                    end
                end
                S_EVAL: begin
                    state_d     = S_DRIVE;
                    colIdx_d    = '0;
                    settleCnt_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Frame bit 4*col+row, so the low two index bits give the row.
    always_comb begin
        nSet   = '0;
        hitIdx = '0;
        for (int i = 0; i < FW; i++) begin
            if (frame_q[i]) begin
                nSet   = nSet + 5'd1;
                hitIdx = 4'(i);
            end
        end
        candClass = NONE;
        candCode  = '0;
        if (nSet == 5'd1) begin
            candClass = KEY;
            candCode  = KEY_MAP[hitIdx[1:0]][hitIdx[3:2]];
        end else if (nSet > 5'd1) begin
            candClass = MULTI;
        end
    end

    always_comb begin
        prevClass_d = prevClass_q;
        prevCode_d  = prevCode_q;
        dbCnt_d     = dbCnt_q;
        commClass_d = commClass_q;
        commCode_d  = commCode_q;

        if ((candClass == prevClass_q) && (candCode == prevCode_q))
            cntNext = (dbCnt_q == DW'(DEBOUNCE_FRAMES)) ? dbCnt_q : dbCnt_q + DW'(1);
        else
            cntNext = DW'(1);
        commitNow = (cntNext == DW'(DEBOUNCE_FRAMES)) &&
                    ((candClass != commClass_q) || (candCode != commCode_q));
        keyPush   = enable && (state_q == S_EVAL) && commitNow && (candClass == KEY);

        if (!enable) begin
            prevClass_d = NONE;
            prevCode_d  = '0;
            dbCnt_d     = '0;
            commClass_d = NONE;
            commCode_d  = '0;
        end else if (state_q == S_EVAL) begin
            prevClass_d = candClass;
            prevCode_d  = candCode;
            dbCnt_d     = cntNext;
            if (commitNow) begin
                commClass_d = candClass;
                commCode_d  = candCode;
            end
        end
    end

    kypd_key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .push_i         (keyPush),
        .push_code_i    (candCode),
        .pop_i          (fifo_pop),
        .clr_overflow_i (clr_overflow),
        .head_o         (key_code),
        .avail_o        (key_avail),
        .count_o        (fifo_count),
        .full_o         (fifoFull),
        .empty_o        (fifoEmpty),
        .overflow_o     (overflow)
    );

    assign col_o     = (state_q == S_IDLE) ? '1 : ~(4'b0001 << colIdx_q);
    assign key_down  = (commClass_q == KEY);
    assign multi_key = (commClass_q == MULTI);
    assign irq       = irq_q;

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Directed bench for kypd_scan_ctrl driving a behavioural 4x4 keypad that
// pulls a row low whenever a pressed key sits on the currently driven column.
module tb_kypd_scan_ctrl;

    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 4 * (SETTLE + 1) + 1;

    logic        clock = 1'b0;
    logic        reset, enable, fifoPop, clrOverflow;
    logic [3:0]  rowIn, colOut, keyCode;
    logic        keyAvail, overflow, keyDown, multiKey, irq;
    logic [2:0]  fifoCount;
    logic [15:0] pressed;
    int          checks = 0;
    int          errors = 0;
    int          phase = 0;
    int          irqSeen = 0;

    always #5 clock = ~clock;

    kypd_scan_ctrl #(
        .SETTLE_CYCLES(SETTLE), .DEBOUNCE_FRAMES(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .row_i(rowIn), .col_o(colOut),
        .fifo_pop(fifoPop), .clr_overflow(clrOverflow), .key_code(keyCode),
        .key_avail(keyAvail), .fifo_count(fifoCount), .overflow(overflow),
        .key_down(keyDown), .multi_key(multiKey), .irq(irq)
    );

    // pressed bit r*4+c means the key at row r, column c is held down.
    always_comb begin
        rowIn = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (colOut[c] === 1'b0)) rowIn[r] = 1'b0;
    end

    function automatic logic [15:0] keyMask(input int r, input int c);
        keyMask = 16'(1) << (r * 4 + c);
    endfunction

    task automatic tick();
        @(negedge clock);
        phase = (phase + 1) % FRAME;
        if (irq === 1'b1) irqSeen++;
    endtask

    task automatic runFrames(input int n);
        repeat (n * FRAME) tick();
    endtask

    task automatic align();
        while (phase != 0) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; fifoPop = 1'b0; clrOverflow = 1'b0; pressed = '0;
        repeat (3) tick();
        checks++;
        if (colOut !== 4'b1111) begin errors++; $display("[TB] FAIL reset_col got %b want 1111", colOut); end
        checks++;
        if ({keyCode, keyAvail, fifoCount, overflow, keyDown, multiKey, irq} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_status got %h want 000",
                     {keyCode, keyAvail, fifoCount, overflow, keyDown, multiKey, irq});
        end
        reset = 1'b0; enable = 1'b1;
    endtask

    task automatic test_scan_order();
        logic [3:0] expCol;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            expCol = (i < FRAME - 1) ? ~(4'b0001 << (i / 5)) : 4'b0111;
            checks++;
            if (colOut !== expCol) begin errors++; $display("[TB] FAIL scan_col cyc %0d got %b want %b", i, colOut, expCol); end
            checks++;
            if ({keyCode, keyAvail, fifoCount, overflow, keyDown, multiKey, irq} !== 12'h000) begin
                errors++; $display("[TB] FAIL scan_status cyc %0d got %h want 000", i,
                                   {keyCode, keyAvail, fifoCount, overflow, keyDown, multiKey, irq});
            end
        end
        tick();
        phase = 0;
        checks++;
        if (colOut !== 4'b1110) begin errors++; $display("[TB] FAIL scan_wrap got %b want 1110", colOut); end
    endtask

    task automatic test_single_key();
        int base = irqSeen;
        pressed = keyMask(1, 1);
        runFrames(1);
        checks++;
        if (irqSeen - base !== 0) begin errors++; $display("[TB] FAIL key5_early_irq got %0d want 0", irqSeen - base); end
        runFrames(1);
        checks++;
        if (irqSeen - base !== 1) begin errors++; $display("[TB] FAIL key5_irq got %0d want 1", irqSeen - base); end
        checks++;
        if ({keyCode, keyAvail, fifoCount, keyDown, multiKey} !== {4'h5, 1'b1, 3'd1, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL key5_state code %h avail %b count %0d down %b multi %b want 5 1 1 1 0",
                               keyCode, keyAvail, fifoCount, keyDown, multiKey);
        end
        runFrames(8);
        checks++;
        if (irqSeen - base !== 1 || fifoCount !== 3'd1) begin
            errors++; $display("[TB] FAIL key5_held irqs %0d count %0d want 1 1", irqSeen - base, fifoCount);
        end
        pressed = '0;
        runFrames(2);
        checks++;
        if (keyDown !== 1'b0) begin errors++; $display("[TB] FAIL key5_release down %b want 0", keyDown); end
        fifoPop = 1'b1; tick(); fifoPop = 1'b0;
        checks++;
        if ({keyCode, keyAvail, fifoCount} !== 8'h00) begin
            errors++; $display("[TB] FAIL key5_pop code %h avail %b count %0d want 0 0 0", keyCode, keyAvail, fifoCount);
        end
        align();
    endtask

    task automatic test_short_press();
        int base = irqSeen;
        pressed = keyMask(2, 2);
        runFrames(1);
        checks++;
        if (keyDown !== 1'b0) begin errors++; $display("[TB] FAIL key9_one_frame down %b want 0", keyDown); end
        pressed = '0;
        runFrames(2);
        checks++;
        if (irqSeen - base !== 0 || fifoCount !== 3'd0 || keyDown !== 1'b0 || keyAvail !== 1'b0) begin
            errors++; $display("[TB] FAIL key9_glitch irqs %0d count %0d down %b avail %b want 0 0 0 0",
                               irqSeen - base, fifoCount, keyDown, keyAvail);
        end
    endtask

    task automatic test_overflow();
        int rowTab[5] = '{0, 0, 0, 0, 3};
        int colTab[5] = '{0, 1, 2, 3, 3};
        logic [3:0] expCodes[4] = '{4'h1, 4'h2, 4'h3, 4'hA};
        int base = irqSeen;
        for (int k = 0; k < 5; k++) begin
            pressed = keyMask(rowTab[k], colTab[k]);
            runFrames(2);
            pressed = '0;
            runFrames(2);
            if (k == 3) begin
                checks++;
                if (fifoCount !== 3'd4 || overflow !== 1'b0) begin
                    errors++; $display("[TB] FAIL fill count %0d ovf %b want 4 0", fifoCount, overflow);
                end
            end
        end
        checks++;
        if (irqSeen - base !== 4 || fifoCount !== 3'd4 || overflow !== 1'b1 || keyCode !== 4'h1) begin
            errors++; $display("[TB] FAIL ovf_set irqs %0d count %0d ovf %b head %h want 4 4 1 1",
                               irqSeen - base, fifoCount, overflow, keyCode);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (keyCode !== expCodes[i] || keyAvail !== 1'b1) begin
                errors++; $display("[TB] FAIL pop_seq %0d code %h avail %b want %h 1", i, keyCode, keyAvail, expCodes[i]);
            end
            fifoPop = 1'b1; tick(); fifoPop = 1'b0;
        end
        checks++;
        if (keyCode !== 4'h0 || keyAvail !== 1'b0 || fifoCount !== 3'd0 || overflow !== 1'b1) begin
            errors++; $display("[TB] FAIL drained code %h avail %b count %0d ovf %b want 0 0 0 1",
                               keyCode, keyAvail, fifoCount, overflow);
        end
        fifoPop = 1'b1; tick(); fifoPop = 1'b0;
        checks++;
        if (fifoCount !== 3'd0 || keyAvail !== 1'b0) begin
            errors++; $display("[TB] FAIL pop_empty count %0d avail %b want 0 0", fifoCount, keyAvail);
        end
        clrOverflow = 1'b1; tick(); clrOverflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b want 0", overflow); end
        align();
    endtask

    task automatic test_multi_key();
        int base = irqSeen;
        pressed = keyMask(0, 0) | keyMask(0, 1);
        runFrames(3);
        checks++;
        if (multiKey !== 1'b1 || keyDown !== 1'b0 || irqSeen - base !== 0 || fifoCount !== 3'd0) begin
            errors++; $display("[TB] FAIL multi multi %b down %b irqs %0d count %0d want 1 0 0 0",
                               multiKey, keyDown, irqSeen - base, fifoCount);
        end
        pressed = keyMask(0, 1);
        runFrames(1);
        checks++;
        if (multiKey !== 1'b1 || irqSeen - base !== 0) begin
            errors++; $display("[TB] FAIL multi_to_key_early multi %b irqs %0d want 1 0", multiKey, irqSeen - base);
        end
        // Pop lands on the same edge as the push into an empty FIFO.
        repeat (FRAME - 1) tick();
        fifoPop = 1'b1; tick(); fifoPop = 1'b0;
        checks++;
        if (irqSeen - base !== 1 || multiKey !== 1'b0 || keyDown !== 1'b1) begin
            errors++; $display("[TB] FAIL multi_to_key irqs %0d multi %b down %b want 1 0 1",
                               irqSeen - base, multiKey, keyDown);
        end
        checks++;
        if (fifoCount !== 3'd1 || keyCode !== 4'h2 || keyAvail !== 1'b1) begin
            errors++; $display("[TB] FAIL push_pop_empty count %0d code %h avail %b want 1 2 1",
                               fifoCount, keyCode, keyAvail);
        end
    endtask

    task automatic test_disable();
        pressed = '0;
        runFrames(2);
        pressed = keyMask(0, 2);
        runFrames(2);
        checks++;
        if (fifoCount !== 3'd2 || keyDown !== 1'b1) begin
            errors++; $display("[TB] FAIL dis_setup count %0d down %b want 2 1", fifoCount, keyDown);
        end
        repeat (7) tick();
        enable = 1'b0;
        tick();
        checks++;
        if (colOut !== 4'b1111 || fifoCount !== 3'd2 || keyCode !== 4'h2 || keyDown !== 1'b0) begin
            errors++; $display("[TB] FAIL disable col %b count %0d code %h down %b want 1111 2 2 0",
                               colOut, fifoCount, keyCode, keyDown);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (fifoCount !== 3'd0 || keyAvail !== 1'b0 || keyCode !== 4'h0 || colOut !== 4'b1111) begin
            errors++; $display("[TB] FAIL dis_reset count %0d avail %b code %h col %b want 0 0 0 1111",
                               fifoCount, keyAvail, keyCode, colOut);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_single_key();
        test_short_press();
        test_overflow();
        test_multi_key();
        test_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/kypd_scan_ctrl.md
Name: kypd_scan_ctrl

Overview:
Scan controller for the Pmod KYPD 4x4 keypad, instantiated inside the PmodKYPD AXI4-Lite peripheral beside the slave register file.
- Drives the column lines one at a time (active-low) and samples the row lines.
- Debounces the per-frame result and pushes decoded key codes into a small FIFO.
- The register file reads the FIFO through a pop strobe and status outputs.

Parameters:
SETTLE_CYCLES, 1000, cycles each column is held low before rows are sampled (min 4)
DEBOUNCE_FRAMES, 4, consecutive identical frames required to commit a new state (min 1)
FIFO_DEPTH, 4, key FIFO entries (power of two, 2..16)

Ports:
clock  in  1  single clock domain
reset  in  1  synchronous, active-high
enable  in  1  scan enable, from control register
row_i  in  4  keypad rows, active-low, asynchronous; row_i[0]=row1
col_o  out  4  keypad columns, active-low; col_o[0]=col1
fifo_pop  in  1  one-cycle strobe; pop FIFO head
clr_overflow  in  1  one-cycle strobe; clear overflow
key_code  out  4  FIFO head code; 0 when empty
key_avail  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky; push dropped while full
key_down  out  1  committed state is a single key
multi_key  out  1  committed state is more than one key
irq  out  1  one-cycle pulse per successful push

Behaviour:
Reset values:
- col_o=4'b1111; all other outputs 0.
- FIFO emptied; debounce state is "none"; FSM in S_IDLE.

Row synchronizer:
- 2-FF synchronizer on row_i; sampled value lags pins by 2 cycles.

FSM:
- S_IDLE: col_o=1111. Leaves to S_DRIVE(col 0) when enable=1.
- S_DRIVE(k): col_o drives bit k low only. Stays SETTLE_CYCLES cycles, then goes to S_SAMPLE(k).
- S_SAMPLE(k): one cycle; latches ~synced_rows into frame bits [4k+3:4k]. k<3 goes to S_DRIVE(k+1); k=3 goes to S_EVAL.
- S_EVAL: one cycle; classifies the frame, updates debounce, may push; then S_DRIVE(0).
- Frame length = 4*(SETTLE_CYCLES+1)+1 cycles.
- enable=0 in any state: S_IDLE on the next edge, col_o=1111 that cycle. Partial frame and debounce counter are discarded; committed state becomes none. FIFO and overflow are retained.

Decode (row, col) to code:
- r1: 1,2,3,A
- r2: 4,5,6,B
- r3: 7,8,9,C
- r4: 0,F,E,D

Classification:
- Frame result is NONE (0 bits set), KEY(code) (exactly 1 bit set) or MULTI (more than 1 bit set).

Debounce:
- cand == prev cand: cnt = cnt+1, saturating at DEBOUNCE_FRAMES.
- Otherwise: cnt = 1.
- cnt == DEBOUNCE_FRAMES and cand != committed: commit cand.
- Commit of KEY(c): push c. This applies from NONE, from MULTI, or from a different KEY.
- Commit of NONE or MULTI: no push.
- key_down and multi_key reflect the committed state.
- A held key pushes exactly once.

FIFO:
- Push and pop take effect at the S_EVAL edge and at the pop edge respectively.
- Pop while empty: ignored.
- Push while full without a same-cycle pop: dropped, overflow=1, irq stays 0.
- Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
- Push and pop in the same cycle while empty: push occurs, pop ignored.
- clr_overflow in the same cycle as a new overflow: set wins.
- key_code and key_avail are registered and valid in the cycle after the push/pop edge.

Decomposition:
- Package kypd_pkg holds:
  - typedef scan_state_t (S_IDLE, S_DRIVE, S_SAMPLE, S_EVAL)
  - typedef frame_class_t (NONE, KEY, MULTI)
  - the 16-entry decode constant array KEY_MAP[row][col]
  - NUM_ROWS=4, NUM_COLS=4
- Sub-module kypd_key_fifo: synchronous FIFO with push, pop, count, full, empty and the overflow flag.

Test Plan:
(Bench uses SETTLE_CYCLES=4, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4; frame = 21 cycles.)
1. Reset, then enable=1 with row_i=1111 -> col_o=1111 during reset, then 1110,1101,1011,0111, each held 5 cycles, then 1 cycle at 0111 (EVAL); all status outputs 0 throughout.
2. Key '5': row_i=1101 while col_o=1101, held 10 frames -> exactly one irq pulse at end of frame 2; key_code=5, key_avail=1, fifo_count=1, key_down=1; no further irq.
3. Key '9' pressed for 1 frame then released -> no push, no irq, fifo_count=0, key_down=0.
4. Press/release keys 1,2,3,A,D with no pops -> fifo_count=4, overflow=1 after D. Four pops -> key_code sequence 1,2,3,A, then 0 with key_avail=0. clr_overflow -> overflow=0.
5. Keys 1 and 2 held together 3 frames -> multi_key=1, no push. Release 1 while 2 stays held -> after 2 frames push code 2, multi_key=0, key_down=1.
6. enable dropped mid-frame with FIFO holding 2 entries -> col_o=1111 next cycle, fifo_count stays 2. reset asserted next -> fifo_count=0, key_avail=0.
